// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with per-byte write enables on one clock.
// Registered read path, optional second output register.
module dual_port_ram_be #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    write_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  always_ff @(posedge clk) begin
    if (write_en && !sync_reset) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[waddr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Write-through merges the enabled din bytes into the read word.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE != 0 && write_en && waddr == raddr) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          rd_word[8*i +: 8] = din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= read_en;
      if (read_en) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    always_ff @(posedge clk) begin
      if (sync_reset) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end

    assign dout       = s2_data;
    assign dout_valid = s2_valid;
  end else begin : g_no_out_reg
    assign dout       = s1_data;
    assign dout_valid = s1_valid;
  end

endmodule
